c5g_qsys_leds_out: RTL and testbench
====================================

# c5g_qsys_leds_out

Avalon-MM slave output port driving the board LEDs (or any output pins) from the Nios II system. Complement to the switches input port. Software writes a data register (directly or through atomic set/clear aliases), and the block drives a registered output bus. A per-bit hardware blink function uses a programmable prescaler. It sits on the Qsys data master interconnect with a fixed read latency of one cycle.

## Interface
- WIDTH, 10: number of output bits (1..32).
- RESET_VALUE, 0: value loaded into the data register and `out_port` at reset.
- PERIOD_RESET, 25000000: reset value of the blink half-period register, in clk cycles (0.5 s at 50 MHz).

- clk  in  1  system clock; all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- address  in  3  word address of register.
- chipselect  in  1  slave select; qualifies writes.
- write_n  in  1  active-low write strobe; write accepted when chipselect=1 and write_n=0.
- writedata  in  32  write data.
- readdata  out  32  registered read data; one-cycle latency; reset 0.
- out_port  out  WIDTH  registered output pins; reset RESET_VALUE.

## Operation
- Register map (word addresses):
  - 0 DATA (RW): data[WIDTH-1:0].
  - 1 BLINK_MASK (RW): mask[WIDTH-1:0]; reset 0.
  - 2 PERIOD (RW): period[31:0]; reset PERIOD_RESET.
  - 3 STATUS (RO): bit0 = blink phase; other bits 0; writes ignored.
  - 4 OUTSET (WO): data <= data | writedata[WIDTH-1:0]; reads return 0.
  - 5 OUTCLEAR (WO): data <= data & ~writedata[WIDTH-1:0]; reads return 0.
  - 6, 7: reserved; reads return 0; writes ignored.
- Bits of writedata above WIDTH are ignored. Bits of readdata above WIDTH read 0.
- Blink prescaler:
  - 32-bit counter `cnt` and a 1-bit `phase`.
  - If period == 0: blinking is disabled; cnt and phase are held at 0.
  - Otherwise cnt increments each cycle. When cnt == period-1, cnt <= 0 and phase toggles.
  - period == 1 therefore toggles phase every cycle.
- Any accepted write to PERIOD sets cnt <= 0 and phase <= 0 in the same edge that loads the new period.
- Output function, registered every cycle: out_port <= data & ~(mask & {WIDTH{phase}}). Masked bits that are set in DATA are forced off during phase=1. Unmasked bits follow DATA.
- readdata is registered every cycle from the current address; no read strobe is used. This matches the input-port convention. Reads have no side effects.
- Reset (synchronous, any cycle, including mid-blink or coincident with a write):
  - data <= RESET_VALUE, mask <= 0, period <= PERIOD_RESET, cnt <= 0, phase <= 0, out_port <= RESET_VALUE, readdata <= 0.
  - Reset has priority over a write in the same cycle; that write is lost.

## Timing
- Write accepted at edge E: the target register holds its new value after E. out_port reflects it after E+1, so write-to-pin latency is 2 edges.
- Read: address presented before edge E, readdata valid after E. A read of a register written at E returns the new value when sampled at E+1.
- Only one write per cycle is possible; OUTSET and OUTCLEAR operate read-modify-write on the register value before the edge.
- Blink terminal count and a PERIOD write in the same cycle: the PERIOD write wins (cnt=0, phase=0, no toggle).
- Blink waveform: with period=P>0 and no PERIOD writes, phase has period 2P cycles and a 50 % duty cycle.
- A write to DATA or BLINK_MASK does not disturb cnt or phase.

## Test plan
- Reset/defaults: hold reset 3 cycles with WIDTH=10 and RESET_VALUE=0x2A5. Required: out_port=0x2A5 and readdata=0. Reading addr 2 returns 25000000, and addr 1 returns 0.
- Write/readback: write DATA=0xFFFFF3C1. Required: out_port=0x3C1 two edges after the write, and a DATA read returns 0x000003C1. A write to addr 6 changes nothing, and reading addr 6, 4 or 5 returns 0.
- Set/clear: starting from DATA=0x00F, write OUTSET=0x300, then OUTCLEAR=0x005 on consecutive cycles. Required: DATA reads 0x30F, then 0x30A; out_port follows 2 edges after each write.
- Blink: DATA=0x3FF, MASK=0x003, PERIOD=4. Required: out_port bits[1:0] alternate 11/00 every 4 cycles, bits[9:2] stay 1, and STATUS bit0 tracks phase. Then write PERIOD=0: bits[1:0] hold 11 and phase stays 0.
- Period restart collision: with PERIOD=3, write PERIOD=5 in the exact cycle cnt==2. Required: no toggle occurs, cnt restarts at 0, and the next toggle comes 5 cycles later.
- Reset mid-operation: assert reset during blink phase=1 in the same cycle as a write DATA=0x155. Required: after the edge DATA=RESET_VALUE, phase=0, period=PERIOD_RESET, and the write is discarded.

Source files
------------

// File: rtl/c5g_qsys_leds_out_if.sv
// Avalon-MM slave bus bundle for the LED output port.
//   address    - word address of the register (0..7)
//   chipselect - slave select; qualifies writes
//   write_n    - active-low write strobe
//   writedata  - write data
//   readdata   - registered read data, one-cycle latency
// The master modport drives the request side and samples readdata.
// The slave modport receives the request and drives readdata.
interface c5g_qsys_leds_out_if;
    logic [2:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;

    modport master (
        output address,
        output chipselect,
        output write_n,
        output writedata,
        input  readdata
    );

    modport slave (
        input  address,
        input  chipselect,
        input  write_n,
        input  writedata,
        output readdata
    );
endinterface

// File: rtl/c5g_qsys_leds_out.sv
// Avalon-MM output port driving board LEDs, with atomic set/clear aliases and a
// per-bit hardware blink driven by a programmable half-period prescaler.
//   clk      - system clock, rising edge
//   reset    - synchronous, active-high reset
//   avs      - Avalon-MM slave bus (address/chipselect/write_n/writedata/readdata)
//   out_port - registered output pins, WIDTH bits
// Register map (word addresses):
//   0 DATA (RW), 1 BLINK_MASK (RW), 2 PERIOD (RW), 3 STATUS (RO, bit0 = phase),
//   4 OUTSET (WO), 5 OUTCLEAR (WO), 6/7 reserved (read 0).
module c5g_qsys_leds_out #(
    parameter int unsigned WIDTH        = 10,
    parameter logic [31:0] RESET_VALUE  = 32'd0,
    parameter logic [31:0] PERIOD_RESET = 32'd25000000
) (
    input  logic                 clk,
    input  logic                 reset,
    c5g_qsys_leds_out_if.slave   avs,
    output logic [WIDTH-1:0]     out_port
);

    localparam logic [2:0] AddrData     = 3'd0;
    localparam logic [2:0] AddrMask     = 3'd1;
    localparam logic [2:0] AddrPeriod   = 3'd2;
    localparam logic [2:0] AddrStatus   = 3'd3;
    localparam logic [2:0] AddrOutSet   = 3'd4;
    localparam logic [2:0] AddrOutClear = 3'd5;

    logic [WIDTH-1:0] data_q, data_d;
    logic [WIDTH-1:0] mask_q, mask_d;
    logic [31:0]      period_q, period_d;
    logic [31:0]      cnt_q, cnt_d;
    logic             phase_q, phase_d;
    logic [WIDTH-1:0] out_d;
    logic [31:0]      readdata_d;

    logic             wr_en;
    logic             period_wr;
    logic [WIDTH-1:0] wdata;

    assign wr_en     = avs.chipselect & ~avs.write_n;
    assign period_wr = wr_en && (avs.address == AddrPeriod);
    assign wdata     = avs.writedata[WIDTH-1:0];

    // Register writes; set/clear are read-modify-write on the pre-edge value.
    always_comb begin
        data_d   = data_q;
        mask_d   = mask_q;
        period_d = period_q;
        if (wr_en) begin
            case (avs.address)
                AddrData:     data_d   = wdata;
                AddrMask:     mask_d   = wdata;
                AddrPeriod:   period_d = avs.writedata;
                AddrOutSet:   data_d   = data_q | wdata;
                AddrOutClear: data_d   = data_q & ~wdata;
                default:      ;
            endcase
        end
    end

    // Blink prescaler. A PERIOD write restarts it and beats a coincident
    // terminal count, so the new period always starts from a clean phase 0.
    always_comb begin
        cnt_d   = cnt_q;
        phase_d = phase_q;
        if (period_wr || (period_q == 32'd0)) begin
            cnt_d   = 32'd0;
            phase_d = 1'b0;
        end else if (cnt_q == period_q - 32'd1) begin
            cnt_d   = 32'd0;
            phase_d = ~phase_q;
        end else begin
            cnt_d = cnt_q + 32'd1;
        end
    end

    // Masked bits are forced off while phase is high.
    assign out_d = data_q & ~(mask_q & {WIDTH{phase_q}});

    // Read mux from current register values; no read strobe, no side effects.
    always_comb begin
        readdata_d = 32'd0;
        case (avs.address)
            AddrData:   readdata_d[WIDTH-1:0] = data_q;
            AddrMask:   readdata_d[WIDTH-1:0] = mask_q;
            AddrPeriod: readdata_d            = period_q;
            AddrStatus: readdata_d[0]         = phase_q;
            default:    ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            data_q       <= RESET_VALUE[WIDTH-1:0];
            mask_q       <= '0;
            period_q     <= PERIOD_RESET;
            cnt_q        <= 32'd0;
            phase_q      <= 1'b0;
            out_port     <= RESET_VALUE[WIDTH-1:0];
            avs.readdata <= 32'd0;
        end else begin
            data_q       <= data_d;
            mask_q       <= mask_d;
            period_q     <= period_d;
            cnt_q        <= cnt_d;
            phase_q      <= phase_d;
            out_port     <= out_d;
            avs.readdata <= readdata_d;
        end
    end

endmodule

// File: tb/tb_c5g_qsys_leds_out.sv
// Directed self-checking bench for c5g_qsys_leds_out. Expected values are
// pushed to a scoreboard queue when stimulus is driven and popped when the
// DUT output is sampled, 1 time unit after the active clock edge.
module tb_c5g_qsys_leds_out;

    localparam int unsigned WIDTH        = 10;
    localparam logic [31:0] RESET_VALUE  = 32'h2A5;
    localparam logic [31:0] PERIOD_RESET = 32'd25000000;

    logic             clk;
    logic             reset;
    logic [WIDTH-1:0] out_port;

    c5g_qsys_leds_out_if bus ();

    c5g_qsys_leds_out #(
        .WIDTH        (WIDTH),
        .RESET_VALUE  (RESET_VALUE),
        .PERIOD_RESET (PERIOD_RESET)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .avs      (bus.slave),
        .out_port (out_port)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       tag;
        logic [31:0] val;
    } exp_t;

    exp_t sb[$];
    int   n_vec = 0;
    int   n_err = 0;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input string tag, input logic [31:0] val);
        exp_t e;
        e.tag = tag;
        e.val = val;
        sb.push_back(e);
    endtask

    task automatic check(input logic [31:0] obs);
        exp_t e;
        n_vec++;
        if (sb.size() == 0) begin
            n_err++;
            $error("FAIL scoreboard_empty: observed %h required an expectation", obs);
        end else begin
            e = sb.pop_front();
            assert (obs === e.val) else begin
                n_err++;
                $error("FAIL %s: observed %h required %h", e.tag, obs, e.val);
            end
        end
    endtask

    task automatic chk_out(input string tag, input logic [WIDTH-1:0] exp);
        push(tag, 32'(exp));
        check(32'(out_port));
    endtask

    task automatic wr(input logic [2:0] addr, input logic [31:0] data);
        bus.address    = addr;
        bus.writedata  = data;
        bus.chipselect = 1'b1;
        bus.write_n    = 1'b0;
        step();
        bus.chipselect = 1'b0;
        bus.write_n    = 1'b1;
    endtask

    task automatic rd(input logic [2:0] addr, input string tag, input logic [31:0] exp);
        bus.address = addr;
        push(tag, exp);
        step();
        check(bus.readdata);
    endtask

    initial begin
        logic ph;

        reset          = 1'b1;
        bus.address    = 3'd0;
        bus.chipselect = 1'b0;
        bus.write_n    = 1'b1;
        bus.writedata  = 32'd0;

        // Reset / defaults
        repeat (3) step();
        chk_out("reset_out_port", 10'h2A5);
        push("reset_readdata", 32'd0);
        check(bus.readdata);
        reset = 1'b0;
        rd(3'd2, "reset_period", 32'd25000000);
        rd(3'd1, "reset_mask", 32'd0);
        rd(3'd0, "reset_data", 32'h2A5);

        // Write / readback, upper writedata bits dropped
        wr(3'd0, 32'hFFFFF3C1);
        chk_out("wr_out_lag1", 10'h2A5);
        step();
        chk_out("wr_out_lag2", 10'h3C1);
        rd(3'd0, "wr_data_read", 32'h0000_03C1);
        wr(3'd6, 32'hFFFFFFFF);
        rd(3'd6, "rsvd6_read", 32'd0);
        rd(3'd4, "outset_read", 32'd0);
        rd(3'd5, "outclear_read", 32'd0);
        rd(3'd0, "rsvd6_nochange", 32'h3C1);
        chk_out("rsvd6_out", 10'h3C1);

        // Set / clear back to back
        wr(3'd0, 32'h00F);
        step();
        chk_out("setclr_base", 10'h00F);
        wr(3'd4, 32'h300);
        chk_out("set_out_lag1", 10'h00F);
        wr(3'd5, 32'h005);
        chk_out("set_out_lag2", 10'h30F);
        push("outclear_readdata", 32'd0);
        check(bus.readdata);
        bus.address = 3'd0;
        step();
        chk_out("clr_out_lag2", 10'h30A);
        push("setclr_data_read", 32'h30A);
        check(bus.readdata);

        // Blink, PERIOD=4: phase high during edges 4..7 after the PERIOD write
        wr(3'd0, 32'h3FF);
        wr(3'd1, 32'h003);
        wr(3'd2, 32'd4);
        bus.address = 3'd3;
        for (int i = 1; i <= 16; i++) begin
            step();
            ph = (((i - 1) / 4) % 2) == 1;
            push("blink_status", {31'd0, ph});
            check(bus.readdata);
            chk_out("blink_out", ph ? 10'h3FC : 10'h3FF);
        end
        wr(3'd2, 32'd0);
        bus.address = 3'd3;
        repeat (2) step();
        for (int i = 0; i < 6; i++) begin
            step();
            push("p0_status", 32'd0);
            check(bus.readdata);
            chk_out("p0_out", 10'h3FF);
        end

        // Period restart collision: PERIOD=5 written while cnt==2 under PERIOD=3
        wr(3'd2, 32'd3);
        bus.address = 3'd3;
        repeat (2) step();
        wr(3'd2, 32'd5);
        bus.address = 3'd3;
        for (int i = 1; i <= 6; i++) begin
            step();
            ph = (i == 6);
            push("collide_status", {31'd0, ph});
            check(bus.readdata);
            chk_out("collide_out", ph ? 10'h3FC : 10'h3FF);
        end

        // Reset during phase=1 with a coincident DATA write
        reset          = 1'b1;
        bus.address    = 3'd0;
        bus.writedata  = 32'h155;
        bus.chipselect = 1'b1;
        bus.write_n    = 1'b0;
        step();
        reset          = 1'b0;
        bus.chipselect = 1'b0;
        bus.write_n    = 1'b1;
        chk_out("rstmid_out", 10'h2A5);
        push("rstmid_readdata", 32'd0);
        check(bus.readdata);
        rd(3'd0, "rstmid_data", 32'h2A5);
        rd(3'd3, "rstmid_phase", 32'd0);
        rd(3'd2, "rstmid_period", 32'd25000000);
        rd(3'd1, "rstmid_mask", 32'd0);
        chk_out("rstmid_out_hold", 10'h2A5);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
